// File: rtl/approx_mac_accumulator.sv
`default_nettype none
// ============================================================================
// Module   : approx_mac_accumulator
// Purpose  : Accumulates approximate-multiplier products into a saturating
//            dot-product sum. The finished sum leaves over valid/ready.
// Revision : 1.0 - initial release
// ============================================================================
module approx_mac_accumulator #(
    parameter int BITWIDTH = 16,
    parameter int ACCWIDTH = 32,
    parameter int CNTWIDTH = 16,
    parameter int SIGNED   = 1
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [BITWIDTH-1:0] in_prod,
    input  logic                in_first,
    input  logic                in_last,
    input  logic [ACCWIDTH-1:0] bias,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [ACCWIDTH-1:0] out_acc,
    output logic                out_sat,
    output logic [CNTWIDTH-1:0] out_count
);

    localparam logic [0:0]          c_ST_ACCUM = 1'b0;
    localparam logic [0:0]          c_ST_HOLD  = 1'b1;
    localparam logic [CNTWIDTH-1:0] c_CNT_ONE  = {{(CNTWIDTH-1){1'b0}}, 1'b1};

    logic [0:0]          r_state;
    logic [0:0]          w_state_next;
    logic [ACCWIDTH-1:0] r_acc;
    logic                r_fresh;
    logic                r_sat;
    logic [CNTWIDTH-1:0] r_cnt;
    logic [ACCWIDTH-1:0] r_out_acc;
    logic                r_out_sat;
    logic [CNTWIDTH-1:0] r_out_count;

    logic                w_accept;
    logic                w_restart;
    logic                w_ovf;
    logic                w_sat_next;
    logic [CNTWIDTH-1:0] w_cnt_next;
    logic [ACCWIDTH-1:0] w_ext;
    logic [ACCWIDTH-1:0] w_base;
    logic [ACCWIDTH-1:0] w_sum;
    logic [ACCWIDTH:0]   w_sum_wide;

    assign in_ready  = (r_state == c_ST_ACCUM) || out_ready;
    assign out_valid = (r_state == c_ST_HOLD);
    assign out_acc   = r_out_acc;
    assign out_sat   = r_out_sat;
    assign out_count = r_out_count;

    assign w_accept  = in_valid && in_ready;
    assign w_restart = in_first || r_fresh;
    // A fresh vector without in_first starts from zero, never from the bias
    assign w_base    = in_first ? bias : (r_fresh ? '0 : r_acc);

    generate
        if (SIGNED != 0) begin : g_signed
            assign w_ext      = {{(ACCWIDTH-BITWIDTH){in_prod[BITWIDTH-1]}}, in_prod};
            assign w_sum_wide = {w_base[ACCWIDTH-1], w_base} + {w_ext[ACCWIDTH-1], w_ext};
            // Top two bits disagree exactly when the signed sum left the range
            assign w_ovf      = w_sum_wide[ACCWIDTH] ^ w_sum_wide[ACCWIDTH-1];
            assign w_sum      = !w_ovf ? w_sum_wide[ACCWIDTH-1:0] :
                                w_sum_wide[ACCWIDTH] ? {1'b1, {(ACCWIDTH-1){1'b0}}} :
                                                       {1'b0, {(ACCWIDTH-1){1'b1}}};
        end else begin : g_unsigned
            assign w_ext      = {{(ACCWIDTH-BITWIDTH){1'b0}}, in_prod};
            assign w_sum_wide = {1'b0, w_base} + {1'b0, w_ext};
            assign w_ovf      = w_sum_wide[ACCWIDTH];
            assign w_sum      = w_ovf ? '1 : w_sum_wide[ACCWIDTH-1:0];
        end
    endgenerate

    assign w_sat_next = w_restart ? w_ovf : (r_sat || w_ovf);
    assign w_cnt_next = w_restart ? c_CNT_ONE : ((&r_cnt) ? r_cnt : r_cnt + c_CNT_ONE);

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            c_ST_ACCUM: begin
                if (w_accept && in_last) w_state_next = c_ST_HOLD;
            end
            c_ST_HOLD: begin
                if (out_ready) w_state_next = (w_accept && in_last) ? c_ST_HOLD : c_ST_ACCUM;
            end
            default: w_state_next = c_ST_ACCUM;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state     <= c_ST_ACCUM;
            r_acc       <= '0;
            r_fresh     <= 1'b1;
            r_sat       <= 1'b0;
            r_cnt       <= '0;
            r_out_acc   <= '0;
            r_out_sat   <= 1'b0;
            r_out_count <= '0;
        end else begin
            r_state <= w_state_next;
            if (w_accept) begin
                r_acc   <= w_sum;
                r_sat   <= w_sat_next;
                r_cnt   <= w_cnt_next;
                r_fresh <= in_last;
                if (in_last) begin
                    r_out_acc   <= w_sum;
                    r_out_sat   <= w_sat_next;
                    r_out_count <= w_cnt_next;
                end
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_approx_mac_accumulator.sv
`default_nettype none
// ============================================================================
// Module   : tb_approx_mac_accumulator
// Purpose  : Drives a signed and an unsigned accumulator in lockstep and
//            scores both against an integer reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_approx_mac_accumulator;

    typedef struct {
        logic [15:0] acc;
        logic        sat;
        logic [15:0] cnt;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic [7:0]  in_prod = '0;
    logic        in_first = 1'b0;
    logic        in_last = 1'b0;
    logic [15:0] bias = '0;
    logic        out_ready = 1'b1;
    logic        in_ready_s, in_ready_u, out_valid_s, out_valid_u;
    logic        out_sat_s, out_sat_u;
    logic [15:0] out_acc_s, out_acc_u, out_count_s, out_count_u;

    int   n_checks = 0;
    int   n_fail = 0;
    bit   bp_rand = 1'b0;
    exp_t q_s[$];
    exp_t q_u[$];

    // reference model state
    int m_acc_s = 0, m_acc_u = 0, m_cnt = 0;
    bit m_fresh = 1'b1, m_sat_s = 1'b0, m_sat_u = 1'b0, m_pending = 1'b0;

    approx_mac_accumulator #(.BITWIDTH(8), .ACCWIDTH(16), .CNTWIDTH(16), .SIGNED(1)) u_dut_s (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready_s),
        .in_prod(in_prod), .in_first(in_first), .in_last(in_last), .bias(bias),
        .out_valid(out_valid_s), .out_ready(out_ready), .out_acc(out_acc_s),
        .out_sat(out_sat_s), .out_count(out_count_s)
    );

    approx_mac_accumulator #(.BITWIDTH(8), .ACCWIDTH(16), .CNTWIDTH(16), .SIGNED(0)) u_dut_u (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready_u),
        .in_prod(in_prod), .in_first(in_first), .in_last(in_last), .bias(bias),
        .out_valid(out_valid_u), .out_ready(out_ready), .out_acc(out_acc_u),
        .out_sat(out_sat_u), .out_count(out_count_u)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: handshakes are decided at the negedge before the edge that takes them
    initial begin
        int base_s, base_u, sum_s, sum_u;
        bit rs, ovf_s, ovf_u, exp_ready, accept;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                m_acc_s = 0; m_acc_u = 0; m_cnt = 0; m_fresh = 1'b1;
                m_sat_s = 1'b0; m_sat_u = 1'b0; m_pending = 1'b0;
                q_s.delete(); q_u.delete();
            end else begin
                exp_ready = !m_pending || out_ready;
                check("in_ready_s", in_ready_s, exp_ready);
                check("in_ready_u", in_ready_u, exp_ready);
                check("out_valid_s", out_valid_s, m_pending);
                check("out_valid_u", out_valid_u, m_pending);
                accept = in_valid && exp_ready;
                if (m_pending && out_ready) m_pending = 1'b0;
                if (accept) begin
                    rs     = in_first || m_fresh;
                    base_s = in_first ? int'($signed(bias)) : (m_fresh ? 0 : m_acc_s);
                    base_u = in_first ? int'(bias) : (m_fresh ? 0 : m_acc_u);
                    sum_s  = base_s + int'($signed(in_prod));
                    sum_u  = base_u + int'(in_prod);
                    ovf_s  = (sum_s > 32767) || (sum_s < -32768);
                    if (sum_s > 32767) sum_s = 32767;
                    else if (sum_s < -32768) sum_s = -32768;
                    ovf_u  = sum_u > 65535;
                    if (ovf_u) sum_u = 65535;
                    m_acc_s = sum_s;
                    m_acc_u = sum_u;
                    m_sat_s = rs ? ovf_s : (m_sat_s || ovf_s);
                    m_sat_u = rs ? ovf_u : (m_sat_u || ovf_u);
                    m_cnt   = rs ? 1 : ((m_cnt < 65535) ? m_cnt + 1 : 65535);
                    m_fresh = in_last;
                    if (in_last) begin
                        q_s.push_back('{acc: 16'(sum_s), sat: m_sat_s, cnt: 16'(m_cnt)});
                        q_u.push_back('{acc: 16'(sum_u), sat: m_sat_u, cnt: 16'(m_cnt)});
                        m_pending = 1'b1;
                    end
                end
            end
        end
    end

    // Output monitor: pops an expectation on every result handshake
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (rst_n && out_valid_s && out_ready) begin
                if (q_s.size() == 0) check("unexpected_out_s", 1, 0);
                else begin
                    e = q_s.pop_front();
                    check("out_acc_s", out_acc_s, e.acc);
                    check("out_sat_s", out_sat_s, e.sat);
                    check("out_count_s", out_count_s, e.cnt);
                end
            end
            if (rst_n && out_valid_u && out_ready) begin
                if (q_u.size() == 0) check("unexpected_out_u", 1, 0);
                else begin
                    e = q_u.pop_front();
                    check("out_acc_u", out_acc_u, e.acc);
                    check("out_sat_u", out_sat_u, e.sat);
                    check("out_count_u", out_count_u, e.cnt);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
        if (bp_rand) out_ready = ($urandom_range(0, 1) == 1);
    endtask

    task automatic send_beat(input logic [7:0] p, input logic [15:0] b, input logic f, input logic l);
        bit taken = 1'b0;
        int waited = 0;
        in_valid = 1'b1; in_prod = p; bias = b; in_first = f; in_last = l;
        while (!taken) begin
            @(negedge clk);
            taken = in_ready_s;
            tick();
            waited++;
            if (!taken && waited > 100) begin
                check("beat_timeout", 0, 1);
                break;
            end
        end
        in_valid = 1'b0; in_prod = 8'($urandom); bias = 16'($urandom);
        in_first = 1'b0; in_last = 1'b0;
    endtask

    task automatic check_idle(input string tag);
        @(negedge clk);
        check({tag, "_acc"}, {out_acc_s, out_acc_u}, 32'h0);
        check({tag, "_sat"}, {out_sat_s, out_sat_u}, 32'h0);
        check({tag, "_count"}, {out_count_s, out_count_u}, 32'h0);
        check({tag, "_valid"}, {out_valid_s, out_valid_u}, 32'h0);
        check({tag, "_ready"}, {in_ready_s, in_ready_u}, 32'h3);
    endtask

    initial begin
        repeat (3) tick();
        rst_n = 1'b1;
        check_idle("reset");
        tick();

        // basic vector: 100 + 3 - 5 + 7
        send_beat(8'd3, 16'd100, 1'b1, 1'b0);
        send_beat(8'hFB, 16'd0, 1'b0, 1'b0);
        send_beat(8'd7, 16'd0, 1'b0, 1'b1);
        tick();

        // positive saturation, then a clean single-beat vector
        send_beat(8'd127, 16'd32700, 1'b1, 1'b0);
        send_beat(8'd127, 16'd0, 1'b0, 1'b0);
        send_beat(8'd127, 16'd0, 1'b0, 1'b1);
        send_beat(8'd1, 16'd0, 1'b1, 1'b1);
        tick();

        // backpressure on a pending 42, then back-to-back -8
        out_ready = 1'b0;
        send_beat(8'd42, 16'd0, 1'b1, 1'b1);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("bp_in_ready", in_ready_s, 1'b0);
            check("bp_out_acc", out_acc_s, 16'd42);
            tick();
        end
        out_ready = 1'b1;
        send_beat(8'hF8, 16'd0, 1'b1, 1'b1);
        @(negedge clk);
        check("b2b_valid", out_valid_s, 1'b1);
        check("b2b_acc", out_acc_s, 16'hFFF8);
        tick();

        // fresh start without in_first: bias must be ignored
        send_beat(8'd10, 16'd999, 1'b0, 1'b0);
        send_beat(8'd20, 16'd999, 1'b0, 1'b1);

        // unsigned saturation and a large unsigned product
        send_beat(8'hFF, 16'd65530, 1'b1, 1'b0);
        send_beat(8'h01, 16'd0, 1'b0, 1'b1);
        send_beat(8'h80, 16'd0, 1'b1, 1'b1);
        tick();

        // reset mid-vector
        send_beat(8'd9, 16'd300, 1'b1, 1'b0);
        send_beat(8'd9, 16'd0, 1'b0, 1'b0);
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        check_idle("midreset");
        tick();
        send_beat(8'd1, 16'd5, 1'b1, 1'b1);
        @(negedge clk);
        check("post_reset_acc", out_acc_s, 16'd6);
        check("post_reset_count", out_count_s, 16'd1);
        tick();

        // randomized traffic with random backpressure and gaps
        bp_rand = 1'b1;
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 3) == 0) tick();
            send_beat(8'($urandom), 16'($urandom), ($urandom_range(0, 7) == 0),
                      ($urandom_range(0, 3) == 0));
        end
        send_beat(8'($urandom), 16'($urandom), 1'b0, 1'b1);
        bp_rand = 1'b0;
        out_ready = 1'b1;
        for (int i = 0; i < 20 && (q_s.size() != 0 || q_u.size() != 0); i++) tick();
        repeat (2) tick();
        check("drain_s", q_s.size(), 0);
        check("drain_u", q_u.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
